// File: rtl/seq_mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mul_pkg
//  Description : Shared constants and FSM state encoding for seq_multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_mul_pkg;

    localparam int c_DEFAULT_WIDTH = 32;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CHECK = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_SIGN  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_CHECK = ST_CHECK,
        S_SHIFT = ST_SHIFT,
        S_SIGN  = ST_SIGN,
        S_DONE  = ST_DONE
    } mul_state_e;

endpackage
`default_nettype wire

// File: rtl/seq_mul_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mul_ctrl
//  Description : Control FSM for the shift-add multiplier. SIGN state is
//                entered only when built with MUL_SIGNED_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_mul_ctrl
    import seq_mul_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic lsb,
    input  logic last,
    output logic load,
    output logic add_en,
    output logic shift_en,
    output logic sign_en,
    output logic done,
    output logic busy
);

    mul_state_e r_state;
    mul_state_e w_nextState;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        load        = 1'b0;
        add_en      = 1'b0;
        shift_en    = 1'b0;
        sign_en     = 1'b0;
        done        = 1'b0;
        busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    load        = 1'b1;
                    w_nextState = S_CHECK;
                end
            end
            S_CHECK: begin
                add_en      = lsb;
                w_nextState = S_SHIFT;
            end
            S_SHIFT: begin
                shift_en = 1'b1;
                if (last) begin
`ifdef MUL_SIGNED_EN
                    w_nextState = S_SIGN;
`else
                    w_nextState = S_DONE;
`endif
                end else begin
                    w_nextState = S_CHECK;
                end
            end
            S_SIGN: begin
                sign_en     = 1'b1;
                w_nextState = S_DONE;
            end
            S_DONE: begin
                done        = 1'b1;
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : seq_multiplier
//  Description : Iterative shift-add multiplier with start/done handshake.
//                Optional signed mode via macro MUL_SIGNED_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_multiplier
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef MUL_SIGNED_EN
    input  logic               signed_op,
`endif
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_product;

    logic               w_load;
    logic               w_addEn;
    logic               w_shiftEn;
    logic               w_signEn;
    logic               w_last;
    logic [WIDTH-1:0]   w_aLoad;
    logic [WIDTH-1:0]   w_bLoad;
    logic               w_neg;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_accShifted;
    logic [2*WIDTH-1:0] w_accSigned;
    logic               w_capture;
    logic [2*WIDTH-1:0] w_captureVal;

    assign w_last       = (r_cnt == c_LAST);
    assign w_sum        = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
    assign w_accShifted = {r_carry, r_acc[2*WIDTH-1:1]};
    assign w_accSigned  = w_neg ? (~r_acc + 1'b1) : r_acc;

`ifdef MUL_SIGNED_EN
    logic r_neg;

    // Operands are iterated as magnitudes; the most-negative value still fits unsigned.
    assign w_aLoad = (signed_op && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign w_bLoad = (signed_op && b[WIDTH-1]) ? (~b + 1'b1) : b;
    assign w_neg   = r_neg;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_neg <= 1'b0;
        end else if (w_load) begin
            r_neg <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
        end
    end

    assign w_capture    = w_signEn;
    assign w_captureVal = w_accSigned;
`else
    assign w_aLoad = a;
    assign w_bLoad = b;
    assign w_neg   = 1'b0;

    // Capture on the final shift so product is already valid while done is high.
    assign w_capture    = w_shiftEn & w_last;
    assign w_captureVal = w_accShifted;
`endif

    seq_mul_ctrl u_ctrl (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .lsb      (r_acc[0]),
        .last     (w_last),
        .load     (w_load),
        .add_en   (w_addEn),
        .shift_en (w_shiftEn),
        .sign_en  (w_signEn),
        .done     (done),
        .busy     (busy)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand   <= '0;
            r_acc     <= '0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            if (w_load) begin
                r_mcand <= w_aLoad;
                r_acc   <= {{WIDTH{1'b0}}, w_bLoad};
                r_carry <= 1'b0;
                r_cnt   <= '0;
            end else if (w_addEn) begin
                {r_carry, r_acc[2*WIDTH-1:WIDTH]} <= w_sum;
            end else if (w_shiftEn) begin
                r_acc   <= w_accShifted;
                r_carry <= 1'b0;
                r_cnt   <= r_cnt + 1'b1;
            end else if (w_signEn) begin
                r_acc   <= w_accSigned;
            end
            if (w_capture) begin
                r_product <= w_captureVal;
            end
        end
    end

    assign product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_seq_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_multiplier
//  Description : Scoreboard bench for seq_multiplier at WIDTH=8 and WIDTH=32.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_multiplier;

`ifdef MUL_SIGNED_EN
    localparam int c_LAT8  = 17;
    localparam int c_LAT32 = 65;
`else
    localparam int c_LAT8  = 16;
    localparam int c_LAT32 = 64;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        busy8;
    logic        done8;
    logic [15:0] product8;
    logic        start32;
    logic [31:0] a32;
    logic [31:0] b32;
    logic        busy32;
    logic        done32;
    logic [63:0] product32;
`ifdef MUL_SIGNED_EN
    logic        signed8;
    logic        signed32;
`endif

    int          checks   = 0;
    int          failures = 0;
    int          doneCnt8 = 0;
    logic [15:0] expQ[$];

    always #5 clk = ~clk;

    always @(negedge clk) if (done8 === 1'b1) doneCnt8++;

    seq_multiplier #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .reset     (reset),
        .start     (start8),
        .a         (a8),
        .b         (b8),
`ifdef MUL_SIGNED_EN
        .signed_op (signed8),
`endif
        .busy      (busy8),
        .done      (done8),
        .product   (product8)
    );

    seq_multiplier #(.WIDTH(32)) dut32 (
        .clk       (clk),
        .reset     (reset),
        .start     (start32),
        .a         (a32),
        .b         (b32),
`ifdef MUL_SIGNED_EN
        .signed_op (signed32),
`endif
        .busy      (busy32),
        .done      (done32),
        .product   (product32)
    );

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One request on the 8-bit unit; optional intruding start while busy.
    task automatic runOp8(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic sg, input logic [15:0] exp, input int intrude);
        int lat;
        int d0;
        logic [15:0] e;
        @(posedge clk); #1;
        start8 = 1'b1;
        a8     = a;
        b8     = b;
`ifdef MUL_SIGNED_EN
        signed8 = sg;
`else
        if (sg) $display("note: signed request in unsigned build");
`endif
        expQ.push_back(exp);
        d0 = doneCnt8;
        @(posedge clk); #1;
        start8 = 1'b0;
        a8     = 8'($urandom);
        b8     = 8'($urandom);
        checkVal({tag, "_busy"}, {63'd0, busy8}, 64'd1);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (i == intrude) begin
                start8 = 1'b1;
                a8     = 8'd2;
                b8     = 8'd2;
            end else if (i == intrude + 1) begin
                start8 = 1'b0;
            end
            if (done8 === 1'b1) begin
                lat = i;
                break;
            end
        end
        checkVal({tag, "_lat"}, 64'(lat), 64'(c_LAT8));
        e = expQ.size() > 0 ? expQ.pop_front() : 16'hxxxx;
        checkVal({tag, "_prod"}, {48'd0, product8}, {48'd0, e});
        repeat (10) @(posedge clk);
        #1;
        checkVal({tag, "_hold"}, {48'd0, product8}, {48'd0, e});
        checkVal({tag, "_ndone"}, 64'(doneCnt8 - d0), 64'd1);
        checkVal({tag, "_idle"}, {63'd0, busy8}, 64'd0);
    endtask

    initial begin
        int          lat;
        int          d0;
        logic [7:0]  ra;
        logic [7:0]  rb;
        reset   = 1'b1;
        start8  = 1'b0;
        a8      = '0;
        b8      = '0;
        start32 = 1'b0;
        a32     = '0;
        b32     = '0;
`ifdef MUL_SIGNED_EN
        signed8  = 1'b0;
        signed32 = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        checkVal("rst_busy", {63'd0, busy8}, 64'd0);
        checkVal("rst_done", {63'd0, done8}, 64'd0);
        checkVal("rst_prod", {48'd0, product8}, 64'd0);
        checkVal("rst_prod32", product32, 64'd0);
        reset = 1'b0;

        runOp8("m13x11", 8'd13, 8'd11, 1'b0, 16'd143, 0);
        runOp8("m255sq", 8'd255, 8'd255, 1'b0, 16'hFE01, 0);
        runOp8("m0x200", 8'd0, 8'd200, 1'b0, 16'd0, 0);
        runOp8("m200x0", 8'd200, 8'd0, 1'b0, 16'd0, 0);
        runOp8("busyreq", 8'd7, 8'd9, 1'b0, 16'd63, 4);
        for (int k = 0; k < 4; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            runOp8("rand", ra, rb, 1'b0, 16'(ra) * 16'(rb), 0);
        end

        // Reset mid-operation aborts with no done.
        @(posedge clk); #1;
        start8 = 1'b1;
        a8     = 8'd100;
        b8     = 8'd100;
        d0     = doneCnt8;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkVal("abort_busy", {63'd0, busy8}, 64'd0);
        checkVal("abort_prod", {48'd0, product8}, 64'd0);
        repeat (20) @(posedge clk);
        #1;
        checkVal("abort_ndone", 64'(doneCnt8 - d0), 64'd0);
        runOp8("m3x4", 8'd3, 8'd4, 1'b0, 16'd12, 0);

`ifdef MUL_SIGNED_EN
        runOp8("s_m3x5", 8'hFD, 8'd5, 1'b1, 16'hFFF1, 0);
        runOp8("s_min2", 8'h80, 8'h80, 1'b1, 16'h4000, 0);
        runOp8("u_FDx5", 8'hFD, 8'd5, 1'b0, 16'd1265, 0);
        for (int k = 0; k < 3; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            runOp8("srand", ra, rb, 1'b1, 16'(int'($signed(ra)) * int'($signed(rb))), 0);
        end
`endif

        // Wide unit: full-width operand times two.
        @(posedge clk); #1;
        start32 = 1'b1;
        a32     = 32'hFFFF_FFFF;
        b32     = 32'd2;
        @(posedge clk); #1;
        start32 = 1'b0;
        a32     = 32'h1234_5678;
        b32     = 32'h9ABC_DEF0;
        checkVal("w32_busy", {63'd0, busy32}, 64'd1);
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (done32 === 1'b1) begin
                lat = i;
                break;
            end
        end
        checkVal("w32_lat", 64'(lat), 64'(c_LAT32));
        checkVal("w32_prod", product32, 64'h1_FFFF_FFFE);
        repeat (5) @(posedge clk);
        #1;
        checkVal("w32_hold", product32, 64'h1_FFFF_FFFE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
